// File: rtl/global_vcfg_tracker_pkg.sv
// global_vcfg_tracker_pkg: vl/vtype types, snapshot layout and vtype/VLMAX/split helpers.
package global_vcfg_tracker_pkg;

    localparam int unsigned XLEN       = 64;
    localparam int unsigned VLENB      = 512;
    localparam int unsigned ClusterNum = 4;
    localparam int unsigned LgClusters = $clog2(ClusterNum);
    localparam int unsigned VlW        = $clog2(8 * VLENB * ClusterNum) + 1;
    localparam int unsigned ClVlW      = $clog2(8 * VLENB) + 1;

    localparam logic [6:0] OpcodeVec     = 7'b1010111;
    localparam logic [6:0] OpcodeLoadFp  = 7'b0000111;
    localparam logic [6:0] OpcodeStoreFp = 7'b0100111;

    typedef logic [VlW-1:0]   vlen_cl_t;
    typedef logic [ClVlW-1:0] vlen_t;
    typedef vlen_t [ClusterNum-1:0] cl_vl_t;

    typedef struct packed {
        logic       vill;
        logic       vma;
        logic       vta;
        logic [2:0] vsew;
        logic [2:0] vlmul;
    } vtype_t;

    typedef struct packed {
        logic            req_valid;
        logic [31:0]     insn;
        logic [XLEN-1:0] rs1;
        logic [XLEN-1:0] rs2;
    } accelerator_req_t;

    typedef struct packed {
        vlen_cl_t vl;
        vtype_t   vtype;
        cl_vl_t   cl_vl;
    } vcfg_snapshot_t;

    localparam vtype_t VtypeIll = '{vill: 1'b1, default: '0};

    function automatic vtype_t vtype_xlen(input logic [XLEN-1:0] x);
        vtype_t v;
        v = '{vill: 1'b0, vma: x[7], vta: x[6], vsew: x[5:3], vlmul: x[2:0]};
        // fractional LMUL needs SEW <= ELEN*LMUL, i.e. vsew < vlmul[1:0]
        return (|x[XLEN-1:8] || v.vsew[2] || v.vlmul == 3'b100 ||
                (v.vlmul[2] && v.vsew[1:0] >= v.vlmul[1:0])) ? VtypeIll : v;
    endfunction

    function automatic vlen_cl_t vlmax_f(input vtype_t vt, input int unsigned nc);
        vlen_cl_t base;
        base = vlen_cl_t'((VLENB * nc) >> vt.vsew);
        if (vt.vill) return '0;
        return vt.vlmul[2] ? base >> (3'd4 - {1'b0, vt.vlmul[1:0]}) : base << vt.vlmul[1:0];
    endfunction

    function automatic cl_vl_t split_vl(input vlen_cl_t vl);
        cl_vl_t   r;
        vlen_cl_t rem;
        rem = vl & vlen_cl_t'(ClusterNum - 1);
        for (int i = 0; i < ClusterNum; i++)
            r[i] = vlen_t'((vl >> LgClusters) + vlen_cl_t'(vlen_cl_t'(i) < rem));
        return r;
    endfunction

endpackage

// File: rtl/global_vcfg_decode.sv
// global_vcfg_decode: combinational vset* / vector LdSt decode producing next vl and vtype.
// GLOBAL_VCFG_MIN_VL_CLAMP_EN lifts small register AVLs to NrClusters*NrLanes.
module global_vcfg_decode
    import global_vcfg_tracker_pkg::*;
#(
    parameter int unsigned NrLanes    = 4,
    parameter int unsigned NrClusters = ClusterNum
) (
    input  logic [31:0]     insn,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  vlen_cl_t        vl_cur,
    output vlen_cl_t        vl_next,
    output vtype_t          vtype_next,
    output logic            is_cfg,
    output logic            is_ldst
);
`ifdef GLOBAL_VCFG_MIN_VL_CLAMP_EN
    localparam bit ClampEn = 1'b1;
`else
    localparam bit ClampEn = 1'b0;
`endif
    localparam vlen_cl_t MinVl = vlen_cl_t'(NrClusters * NrLanes);

    logic     ivli, rs1_x0, rd_x0;
    vlen_cl_t vlmax, avl;

    always_comb begin
        is_cfg     = insn[6:0] == OpcodeVec && insn[14:12] == 3'b111;
        is_ldst    = (insn[6:0] == OpcodeLoadFp || insn[6:0] == OpcodeStoreFp) &&
                     (insn[14:12] == 3'b000 || (insn[14] && insn[13:12] != 2'b00));
        ivli       = insn[31:30] == 2'b11;
        rs1_x0     = insn[19:15] == 5'd0;
        rd_x0      = insn[11:7] == 5'd0;
        vtype_next = vtype_xlen(insn[31] && !ivli ? rs2 :
                                ivli ? XLEN'(insn[29:20]) : XLEN'(insn[30:20]));
        vlmax      = vlmax_f(vtype_next, NrClusters);
        avl        = ivli ? vlen_cl_t'(insn[19:15]) :
                     !rs1_x0 ? (|rs1[XLEN-1:VlW] ? vlmax : rs1[VlW-1:0]) :
                     rd_x0 ? vl_cur : vlmax;
        if (ClampEn && !ivli && !rs1_x0 && avl != '0 && avl < MinVl) avl = MinVl;
        vl_next    = avl < vlmax ? avl : vlmax;
    end

endmodule

// File: rtl/global_vcfg_tracker.sv
// global_vcfg_tracker: architectural vl/vtype tracking plus a per-LdSt config snapshot queue.
// Optional GLOBAL_VCFG_MIN_VL_CLAMP_EN (see global_vcfg_decode) enables the minimum-vl clamp.
module global_vcfg_tracker
    import global_vcfg_tracker_pkg::*;
#(
    parameter int unsigned NrLanes    = 4,
    parameter int unsigned NrClusters = ClusterNum,
    parameter int unsigned Depth      = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   flush_i,
    input  accelerator_req_t       acc_req_i,
    output logic                   acc_ready_o,
    output logic                   snap_valid_o,
    input  logic                   snap_ready_i,
    output vcfg_snapshot_t         snap_o,
    output vlen_cl_t               vl_o,
    output vtype_t                 vtype_o,
    output vlen_cl_t               vlmax_o,
    output logic [$clog2(Depth):0] usage_o
);
    localparam int unsigned     PtrW    = $clog2(Depth);
    localparam logic [PtrW-1:0] LastPtr = PtrW'(Depth - 1);
    localparam logic [PtrW:0]   FullCnt = (PtrW + 1)'(Depth);

    vcfg_snapshot_t  mem [Depth];
    vcfg_snapshot_t  last;
    logic [PtrW-1:0] wr_ptr, rd_ptr;
    vlen_cl_t        vl, vl_next;
    vtype_t          vtype, vtype_next;
    logic            is_cfg, is_ldst, full, pop, push, accept;

    global_vcfg_decode #(.NrLanes(NrLanes), .NrClusters(NrClusters)) i_decode (
        .insn      (acc_req_i.insn),
        .rs1       (acc_req_i.rs1),
        .rs2       (acc_req_i.rs2),
        .vl_cur    (vl),
        .vl_next   (vl_next),
        .vtype_next(vtype_next),
        .is_cfg    (is_cfg),
        .is_ldst   (is_ldst)
    );

    // Only LdSt needs a free slot; a pop in the same cycle frees one.
    always_comb begin
        full         = usage_o == FullCnt;
        snap_valid_o = usage_o != '0;
        pop          = snap_valid_o && snap_ready_i;
        acc_ready_o  = !full || pop || (acc_req_i.req_valid && !is_ldst);
        accept       = acc_req_i.req_valid && acc_ready_o;
        push         = accept && is_ldst && !flush_i;
        snap_o       = snap_valid_o ? mem[rd_ptr] : last;
        vl_o         = vl;
        vtype_o      = vtype;
        vlmax_o      = vlmax_f(vtype, NrClusters);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            vl      <= '0;
            vtype   <= VtypeIll;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            usage_o <= '0;
            last    <= '0;
        end else begin
            if (accept && is_cfg) begin
                vl    <= vl_next;
                vtype <= vtype_next;
            end
            if (pop) last <= mem[rd_ptr];
            if (flush_i) begin
                wr_ptr  <= '0;
                rd_ptr  <= '0;
                usage_o <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr == LastPtr ? '0 : wr_ptr + 1'b1;
                if (pop) rd_ptr <= rd_ptr == LastPtr ? '0 : rd_ptr + 1'b1;
                usage_o <= usage_o + (PtrW + 1)'(push) - (PtrW + 1)'(pop);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) mem[wr_ptr] <= '{vl: vl, vtype: vtype, cl_vl: split_vl(vl)};
    end

endmodule

// File: tb/tb_global_vcfg_tracker.sv
// tb_global_vcfg_tracker: directed vectors; expected snapshots go to a queue checked by a pop monitor.
module tb_global_vcfg_tracker;
    import global_vcfg_tracker_pkg::*;

`ifdef GLOBAL_VCFG_MIN_VL_CLAMP_EN
    localparam int Vl5 = 16;
`else
    localparam int Vl5 = 5;
`endif

    logic             clk_i = 1'b0, rst_ni = 1'b1, flush_i = 1'b0, snap_ready_i = 1'b0;
    accelerator_req_t acc_req_i = '0;
    logic             acc_ready_o, snap_valid_o;
    vcfg_snapshot_t   snap_o;
    vlen_cl_t         vl_o, vlmax_o;
    vtype_t           vtype_o;
    logic [2:0]       usage_o;
    vcfg_snapshot_t   exp_q[$];
    int               n_vec = 0, n_err = 0;

    global_vcfg_tracker #(.NrLanes(4), .NrClusters(4), .Depth(4)) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .flush_i     (flush_i),
        .acc_req_i   (acc_req_i),
        .acc_ready_o (acc_ready_o),
        .snap_valid_o(snap_valid_o),
        .snap_ready_i(snap_ready_i),
        .snap_o      (snap_o),
        .vl_o        (vl_o),
        .vtype_o     (vtype_o),
        .vlmax_o     (vlmax_o),
        .usage_o     (usage_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [31:0] vsetvli(input logic [4:0] rd, rs1, input logic [10:0] zimm);
        return {1'b0, zimm, rs1, 3'b111, rd, OpcodeVec};
    endfunction

    function automatic logic [31:0] vsetivli(input logic [4:0] rd, uimm, input logic [9:0] zimm);
        return {2'b11, zimm, uimm, 3'b111, rd, OpcodeVec};
    endfunction

    function automatic logic [31:0] vldst(input logic st, input logic [2:0] width);
        return {12'h000, 5'd10, width, 5'd8, st ? OpcodeStoreFp : OpcodeLoadFp};
    endfunction

    function automatic vcfg_snapshot_t snap(input int vl, input logic [8:0] vt, input int c0, c1, c2, c3);
        vcfg_snapshot_t s;
        s.vl       = vlen_cl_t'(vl);
        s.vtype    = vt;
        s.cl_vl[0] = vlen_t'(c0);
        s.cl_vl[1] = vlen_t'(c1);
        s.cl_vl[2] = vlen_t'(c2);
        s.cl_vl[3] = vlen_t'(c3);
        return s;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic req(input logic [31:0] insn, input logic [63:0] r1);
        logic ok;
        acc_req_i = '{req_valid: 1'b1, insn: insn, rs1: r1, rs2: '0};
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk_i);
            ok = acc_ready_o;
        end
        if (!ok) begin
            n_vec++;
            n_err++;
            $display("FAIL req_accept: acc_ready_o stuck at 0, required 1");
        end
        @(posedge clk_i);
        #1 acc_req_i = '0;
    endtask

    task automatic cfg(input string name, input logic [31:0] insn, input logic [63:0] r1,
                       input int evl, input logic [8:0] evt, input int emax);
        req(insn, r1);
        chk({name, "_vl"}, vl_o, evl);
        chk({name, "_vtype"}, vtype_o, evt);
        chk({name, "_vlmax"}, vlmax_o, emax);
    endtask

    always @(negedge clk_i) begin
        if (rst_ni && snap_valid_o && snap_ready_i) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL snap_pop: got %0h, required no snapshot", snap_o);
            end else chk("snap", snap_o, exp_q.pop_front());
        end
    end

    initial begin
        #2 rst_ni = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        chk("rst_vl", vl_o, 0);
        chk("rst_vtype", vtype_o, 9'h100);
        chk("rst_vlmax", vlmax_o, 0);
        chk("rst_usage", usage_o, 0);
        chk("rst_valid", snap_valid_o, 0);
        chk("rst_ready", acc_ready_o, 1);
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1 snap_ready_i = 1'b1;
        cfg("vsetvli_1000", vsetvli(1, 5, 11'h010), 1000, 512, 9'h010, 512);
        cfg("vsetivli_10", vsetivli(1, 10, 10'h000), 0, 10, 9'h000, 2048);
        exp_q.push_back(snap(10, 9'h000, 3, 3, 2, 2));
        req(vldst(0, 3'b000), 0);
        cfg("e64mf8", vsetvli(1, 5, 11'h01D), 64, 0, 9'h100, 0);
        exp_q.push_back(snap(0, 9'h100, 0, 0, 0, 0));
        req(vldst(1, 3'b111), 0);
        repeat (2) @(posedge clk_i);
        #1 snap_ready_i = 1'b0;
        cfg("reconfig", vsetvli(1, 5, 11'h010), 1000, 512, 9'h010, 512);
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(snap(512, 9'h010, 128, 128, 128, 128));
            req(vldst(0, 3'b110), 0);
        end
        chk("usage_full", usage_o, 4);
        acc_req_i = '{req_valid: 1'b1, insn: vldst(0, 3'b110), rs1: '0, rs2: '0};
        @(negedge clk_i);
        chk("full_stall", acc_ready_o, 0);
        @(posedge clk_i);
        #1 snap_ready_i = 1'b1;
        @(negedge clk_i);
        chk("full_pop_ready", acc_ready_o, 1);
        exp_q.push_back(snap(512, 9'h010, 128, 128, 128, 128));
        @(posedge clk_i);
        #1 acc_req_i = '0;
        chk("usage_push_pop", usage_o, 4);
        for (int i = 0; i < 20 && usage_o != 0; i++) @(posedge clk_i);
        #1;
        chk("usage_drained", usage_o, 0);
        chk("queue_drained", exp_q.size(), 0);
        snap_ready_i = 1'b0;
        cfg("x0_rd", vsetvli(1, 0, 11'h000), 0, 2048, 9'h000, 2048);
        cfg("x0_x0", vsetvli(0, 0, 11'h018), 0, 256, 9'h018, 256);
        cfg("rs1_upper", vsetvli(1, 5, 11'h010), 64'h1_0000_0000, 512, 9'h010, 512);
        cfg("vsetivli_5", vsetivli(1, 5, 10'h010), 0, 5, 9'h010, 512);
        cfg("avl_zero", vsetvli(1, 5, 11'h010), 0, 0, 9'h010, 512);
        cfg("avl_5", vsetvli(1, 5, 11'h010), 5, Vl5, 9'h010, 512);
        for (int i = 0; i < 3; i++) req(vldst(0, 3'b110), 0);
        chk("usage_3", usage_o, 3);
        acc_req_i = '{req_valid: 1'b1, insn: vldst(0, 3'b110), rs1: '0, rs2: '0};
        flush_i = 1'b1;
        @(posedge clk_i);
        #1;
        acc_req_i = '0;
        flush_i = 1'b0;
        chk("flush_usage", usage_o, 0);
        chk("flush_valid", snap_valid_o, 0);
        chk("flush_vl", vl_o, Vl5);
        chk("snap_hold", snap_o, snap(512, 9'h010, 128, 128, 128, 128));
        req(vldst(0, 3'b110), 0);
        chk("pre_rst_usage", usage_o, 1);
        #3 rst_ni = 1'b0;
        #1;
        chk("arst_usage", usage_o, 0);
        chk("arst_valid", snap_valid_o, 0);
        chk("arst_vl", vl_o, 0);
        chk("arst_vtype", vtype_o, 9'h100);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

endmodule
